// File: rtl/motor_pkg.sv
// Shared types for the motor ramp controller: dir encodings, FSM states and the
// saturating step helper.
package motor_pkg;

    localparam int unsigned SPEED_MAX = 1023;
    localparam int unsigned SPEED_W   = $clog2(SPEED_MAX + 1);

    typedef enum logic [1:0] {
        BACKWARD = 2'b00,
        LEFT     = 2'b01,
        RIGHT    = 2'b10,
        FORWARD  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        StHold,
        StRamp,
        StBrake,
        StDead
    } state_e;

    // One ramp step toward tgt, done one bit wider so it can never wrap or overshoot.
    function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                       input logic [SPEED_W-1:0] tgt,
                                                       input logic [SPEED_W:0]   step);
        logic [SPEED_W:0] c;
        logic [SPEED_W:0] t;
        logic [SPEED_W:0] diff;
        logic [SPEED_W:0] nxt;
        c    = {1'b0, cur};
        t    = {1'b0, tgt};
        diff = (t >= c) ? (t - c) : (c - t);
        if (diff <= step) begin
            nxt = t;
        end else if (t > c) begin
            nxt = c + step;
        end else begin
            nxt = c - step;
        end
        return nxt[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/motor_ramp_ctrl_if.sv
// Command handshake between a motion master and the ramp controller.
interface motor_ramp_ctrl_if;
    import motor_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    dir_e               cmd_dir;
    logic [SPEED_W-1:0] cmd_speed;

    modport master (output cmd_valid, output cmd_dir, output cmd_speed, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_dir, input cmd_speed, output cmd_ready);

endinterface

// File: rtl/motor_ramp_ctrl_ramp_tick.sv
// Ramp prescaler: tick is high while the count sits at RAMP_DIV-1; clr restarts the period.
module motor_ramp_ctrl_ramp_tick #(
    parameter int unsigned RAMP_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == CntW'(RAMP_DIV - 1));
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Motion sequencer in front of the Motor block: ramps speed, brakes and waits a dead time
// before any direction reversal. Optional emergency stop: MOTOR_RAMP_CTRL_ESTOP_EN.
module motor_ramp_ctrl
    import motor_pkg::*;
#(
    parameter int unsigned RAMP_DIV = 100_000,
    parameter int unsigned STEP     = 32,
    parameter int unsigned DEAD_CYC = 5_000_000
) (
    input  logic               c100MHz,
    input  logic               rst,
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    input  logic               estop,
`endif
    motor_ramp_ctrl_if.slave   cmd,
    output dir_e               dir,
    output logic [SPEED_W-1:0] speed,
    output logic               at_speed,
    output logic               busy
);

    localparam int unsigned    DeadW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [SPEED_W:0] StepV = (SPEED_W + 1)'(STEP);

    state_e             state_q, state_d;
    dir_e               dir_q, dir_d;
    dir_e               pend_dir_q, pend_dir_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [SPEED_W-1:0] target_q, target_d;
    logic [SPEED_W-1:0] pend_speed_q, pend_speed_d;
    logic [DeadW-1:0]   dead_cnt_q, dead_cnt_d;
    logic               tick;
    logic               clr;
    logic               accept;
    logic               dead_done;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    logic               estop_q, estop_d;
`endif

    motor_ramp_ctrl_ramp_tick #(
        .RAMP_DIV (RAMP_DIV)
    ) u_ramp_tick (
        .clk  (c100MHz),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    assign cmd.cmd_ready = ((state_q == StHold) || (state_q == StRamp)) && !estop_q;
`else
    assign cmd.cmd_ready = (state_q == StHold) || (state_q == StRamp);
`endif
    assign accept    = cmd.cmd_valid && cmd.cmd_ready;
    assign dead_done = (dead_cnt_q == DeadW'(DEAD_CYC - 1));

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        speed_d      = speed_q;
        target_d     = target_q;
        pend_dir_d   = pend_dir_q;
        pend_speed_d = pend_speed_q;
        dead_cnt_d   = dead_cnt_q;
        clr          = 1'b0;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        estop_d      = estop_q;
`endif
        unique case (state_q)
            StHold, StRamp: begin
                if (accept) begin
                    clr = 1'b1;
                    if (cmd.cmd_dir == dir_q) begin
                        target_d = cmd.cmd_speed;
                        state_d  = StRamp;
                    end else if (speed_q == '0) begin
                        dir_d    = cmd.cmd_dir;
                        target_d = cmd.cmd_speed;
                        state_d  = StRamp;
                    end else begin
                        // Reversal at speed: park the command and brake first.
                        pend_dir_d   = cmd.cmd_dir;
                        pend_speed_d = cmd.cmd_speed;
                        target_d     = '0;
                        state_d      = StBrake;
                    end
                end else if (state_q == StRamp) begin
                    if (speed_q == target_q) begin
                        state_d = StHold;
                    end else if (tick) begin
                        speed_d = step_toward(speed_q, target_q, StepV);
                        if (speed_d == target_q) begin
                            state_d = StHold;
                        end
                    end
                end
            end
            StBrake: begin
                if (speed_q == '0) begin
                    state_d    = StDead;
                    dead_cnt_d = '0;
                end else if (tick) begin
                    speed_d = step_toward(speed_q, '0, StepV);
                    if (speed_d == '0) begin
                        state_d    = StDead;
                        dead_cnt_d = '0;
                    end
                end
            end
            StDead: begin
                if (dead_done) begin
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
                    if (estop_q) begin
                        state_d = StHold;
                        estop_d = 1'b0;
                    end else
`endif
                    begin
                        dir_d    = pend_dir_q;
                        target_d = pend_speed_q;
                        state_d  = StRamp;
                        clr      = 1'b1;
                    end
                end else begin
                    dead_cnt_d = dead_cnt_q + DeadW'(1);
                end
            end
            default: state_d = StHold;
        endcase
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        // Emergency stop overrides any accept or tick decided above.
        if (estop) begin
            dir_d        = dir_q;
            speed_d      = '0;
            target_d     = '0;
            pend_dir_d   = FORWARD;
            pend_speed_d = '0;
            dead_cnt_d   = '0;
            state_d      = StDead;
            estop_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge c100MHz) begin
        if (rst) begin
            state_q      <= StHold;
            dir_q        <= FORWARD;
            speed_q      <= '0;
            target_q     <= '0;
            pend_dir_q   <= FORWARD;
            pend_speed_q <= '0;
            dead_cnt_q   <= '0;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
            estop_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            speed_q      <= speed_d;
            target_q     <= target_d;
            pend_dir_q   <= pend_dir_d;
            pend_speed_q <= pend_speed_d;
            dead_cnt_q   <= dead_cnt_d;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
            estop_q      <= estop_d;
`endif
        end
    end

    assign dir      = dir_q;
    assign speed    = speed_q;
    assign at_speed = (state_q == StHold);
    assign busy     = (state_q != StHold);

    a_dir_change_at_zero: assert property (@(posedge c100MHz) disable iff (rst)
        (dir_d != dir_q) |-> (speed_q == '0));

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Scoreboard bench for motor_ramp_ctrl: a reference model predicts every dir/speed change
// with its cycle; a monitor pops and compares whenever the outputs move.
module tb_motor_ramp_ctrl;
    import motor_pkg::*;

    localparam int RampDiv = 4;
    localparam int Step    = 100;
    localparam int DeadCyc = 8;

    typedef struct {
        int   t;
        dir_e d;
        int   s;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
    logic estop;
`endif
    dir_e       dir;
    logic [9:0] speed;
    logic       at_speed;
    logic       busy;

    motor_ramp_ctrl_if cmd_if ();

    motor_ramp_ctrl #(
        .RAMP_DIV (RampDiv),
        .STEP     (Step),
        .DEAD_CYC (DeadCyc)
    ) dut (
        .c100MHz  (clk),
        .rst      (rst),
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        .estop    (estop),
`endif
        .cmd      (cmd_if),
        .dir      (dir),
        .speed    (speed),
        .at_speed (at_speed),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  exp_q[$];
    dir_e cur_dir = FORWARD;
    int   cur_speed = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every visible change of dir/speed must match the next predicted event.
    initial begin
        dir_e       prev_dir;
        logic [9:0] prev_speed;
        ev_t        e;
        prev_dir   = FORWARD;
        prev_speed = '0;
        forever begin
            @(negedge clk);
            if (mon_en && (dir !== prev_dir || speed !== prev_speed)) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d: got dir=%b speed=%0d, required no change",
                             cyc, dir, speed);
                end else begin
                    e = exp_q.pop_front();
                    if (e.t != cyc || e.d !== dir || e.s != int'(speed)) begin
                        miscompares++;
                        $display("FAIL event: got cyc=%0d dir=%b speed=%0d, required cyc=%0d dir=%b speed=%0d",
                                 cyc, dir, speed, e.t, e.d, e.s);
                    end
                    cur_dir   = e.d;
                    cur_speed = e.s;
                end
            end
            prev_dir   = dir;
            prev_speed = speed;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input int t, input dir_e d, input int s);
        ev_t e;
        e.t = t;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // Speed moves by Step per RampDiv cycles, landing exactly on the target.
    task automatic ramp(input int t0, input dir_e d, input int from, input int to,
                        output int tend);
        int c = from;
        int k = 0;
        while (c != to) begin
            k++;
            if (((to > c) ? to - c : c - to) <= Step) c = to;
            else if (to > c) c = c + Step;
            else c = c - Step;
            push(t0 + RampDiv * k, d, c);
        end
        tend = t0 + RampDiv * k;
    endtask

    task automatic predict(input int ta, input dir_e d, input int s);
        int te;
        if (d == cur_dir) begin
            ramp(ta, d, cur_speed, s, te);
        end else if (cur_speed == 0) begin
            push(ta, d, 0);
            ramp(ta, d, 0, s, te);
        end else begin
            ramp(ta, cur_dir, cur_speed, 0, te);
            push(te + DeadCyc, d, 0);
            ramp(te + DeadCyc, d, 0, s, te);
        end
    endtask

    // Called and returns at negedge+1.
    task automatic issue(input dir_e d, input int s);
        int n = 0;
        while (cmd_if.cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (cmd_if.cmd_ready !== 1'b1) begin
            check("ready_wait", 0, 1);
            return;
        end
        exp_q.delete();
        predict(cyc + 1, d, s);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_dir   = d;
        cmd_if.cmd_speed = 10'(s);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = dir_e'(2'($urandom_range(0, 3)));
        cmd_if.cmd_speed = 10'($urandom_range(0, 1023));
        @(negedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_speed(input int s);
        int n = 0;
        while (cur_speed != s && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (cur_speed != s) check("wait_speed", cur_speed, s);
    endtask

    function automatic bit pending_reversal();
        foreach (exp_q[i]) if (exp_q[i].d != cur_dir) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_dir"}, int'(dir), 3);
        check({tag, "_speed"}, int'(speed), 0);
        check({tag, "_at_speed"}, int'(at_speed), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_cmd_ready"}, int'(cmd_if.cmd_ready), 1);
    endtask

    initial begin
        int   n;
        dir_e rd;
        int   rs;
        rst              = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = FORWARD;
        cmd_if.cmd_speed = '0;
`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        estop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Ramp up from standstill.
        issue(FORWARD, 350);
        drain();
        check("hold_at_speed", int'(at_speed), 1);
        check("hold_busy", int'(busy), 0);
        check("hold_speed", int'(speed), 350);

        // Reversal: brake, dead time, then switch.
        issue(BACKWARD, 200);
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check("brake_ready", int'(cmd_if.cmd_ready), 0);
        check("brake_busy", int'(busy), 1);
        wait_speed(0);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        check("dead_ready", int'(cmd_if.cmd_ready), 0);
        check("dead_dir_held", int'(dir), 3);
        drain();
        check("rev_dir", int'(dir), 0);
        check("rev_speed", int'(speed), 200);

        // Extremes: no wrap going down, single short step to full scale.
        issue(BACKWARD, 1023);
        drain();
        issue(BACKWARD, 0);
        drain();
        check("down_to_zero", int'(speed), 0);
        issue(BACKWARD, 1000);
        drain();
        issue(BACKWARD, 1023);
        drain();
        check("full_scale", int'(speed), 1023);

        // Retarget mid-ramp.
        issue(BACKWARD, 0);
        drain();
        issue(BACKWARD, 800);
        wait_speed(200);
        issue(BACKWARD, 250);
        drain();
        check("retarget_speed", int'(speed), 250);
        check("retarget_at_speed", int'(at_speed), 1);

        // Reset while in dead time drops the pending command.
        issue(FORWARD, 500);
        wait_speed(0);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_reset_state("dead_reset");
        #1;
        rst = 1'b0;
        exp_q.delete();
        cur_dir   = FORWARD;
        cur_speed = 0;
        mon_en    = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #1;
        end
        check("pending_lost_speed", int'(speed), 0);
        check("pending_lost_at_speed", int'(at_speed), 1);

        // Random commands, including retargets while a same-direction ramp is in flight.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 15)) begin
                @(negedge clk);
                #1;
            end
            n = 0;
            while (pending_reversal() && n < 2000) begin
                @(negedge clk);
                #1;
                n++;
            end
            rd = ($urandom_range(0, 2) == 0) ? dir_e'(2'($urandom_range(0, 3))) : cur_dir;
            case ($urandom_range(0, 3))
                0: rs = 0;
                1: rs = 1023;
                default: rs = int'($urandom_range(0, 1023));
            endcase
            issue(rd, rs);
        end
        drain();
        check("random_at_speed", int'(at_speed), 1);
        check("random_busy", int'(busy), 0);

`ifdef MOTOR_RAMP_CTRL_ESTOP_EN
        issue(cur_dir, 500);
        drain();
        push(cyc + 1, cur_dir, 0);
        estop = 1'b1;
        @(posedge clk);
        #1;
        estop = 1'b0;
        check("estop_speed", int'(speed), 0);
        repeat (7) @(posedge clk);
        #1;
        check("estop_dead_at_speed", int'(at_speed), 0);
        check("estop_dead_ready", int'(cmd_if.cmd_ready), 0);
        @(posedge clk);
        #1;
        check("estop_hold_at_speed", int'(at_speed), 1);
        check("estop_hold_ready", int'(cmd_if.cmd_ready), 1);
        @(negedge clk);
        #1;
        issue(cur_dir, 300);
        drain();
        check("estop_recover_speed", int'(speed), 300);
`endif

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
